// File: rtl/dmem_byte_sync.sv
// Byte-lane writable data memory with a synchronous read port.
// After reset the array is optionally swept to zero one word per cycle;
// requests are only accepted once the sweep has finished (ready high).
module dmem_byte_sync #(
   parameter int unsigned DEPTH_WORDS    = 64,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_write,
   input  logic [3:0]  data_write_byte,
   input  logic        data_write_valid,
   input  logic        data_read_valid,
   output logic [31:0] data_read,
   output logic        data_read_ack,
   output logic        ready,
   output logic        addr_error
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [AW-1:0]   clr_cnt;
   logic            clear_we;
   logic [31:0]     mem [DEPTH_WORDS];

   logic [AW-1:0]   word_idx;
   logic            in_range;
   logic            rd_acc;
   logic            wr_acc;
   logic            addr_low_unused;

   // Byte offset within a word carries no meaning for a word-wide port.
   assign addr_low_unused = ^data_addr[1:0];

   assign word_idx = data_addr[AW+1:2];
   assign in_range = (data_addr[31:2] < 30'(DEPTH_WORDS));
   assign rd_acc   = ready & data_read_valid;
   // A write with no lanes enabled is not a request at all: no write, no error.
   assign wr_acc   = ready & data_write_valid & (|data_write_byte);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic, ready and clear-write strobe.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      clear_we   = 1'b0;
      case (state)
         CLEAR: begin
            if (CLEAR_ON_RESET == 1'b0) begin
               state_next = IDLE;
            end else begin
               clear_we = 1'b1;
               if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                  state_next = IDLE;
               end
            end
         end
         IDLE: begin
            ready = 1'b1;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // Clear sweep word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_cnt <= '0;
      end else if (clear_we) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // Storage: clear sweep or per-lane write; nothing happens in a reset cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clear_we) begin
            mem[clr_cnt] <= '0;
         end else if (wr_acc && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (data_write_byte[i]) begin
                  mem[word_idx][8*i +: 8] <= data_write[8*i +: 8];
               end
            end
         end
      end
   end

   // Registered read data, ack and error pulses; read sees pre-edge contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_read     <= '0;
         data_read_ack <= 1'b0;
         addr_error    <= 1'b0;
      end else begin
         data_read_ack <= rd_acc;
         addr_error    <= (rd_acc | wr_acc) & ~in_range;
         if (rd_acc) begin
            data_read <= in_range ? mem[word_idx] : '0;
         end
      end
   end

endmodule
